// File: rtl/fetch_pkg.sv
// Shared constants, slot layout and FSM states for the instruction-fetch stage.
// Defining IFETCH_MISALIGN_CHK_EN adds a per-slot misalign flag.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
`ifdef IFETCH_MISALIGN_CHK_EN
        logic        misalign;
`endif
    } slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// Circular slot queue pairing issued fetch PCs with their in-order responses.
// IFETCH_MISALIGN_CHK_EN enables storage of the misalign flag.
module fetch_slot_queue
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_prefilled,
    input  logic             fill,
    input  logic [31:0]      fill_instr,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] pend,
    output slot_t            head_slot
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    slot_t            slots_q [DEPTH];
    slot_t            slots_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    always_comb begin
        slots_d = slots_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;
        count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
        pend_d  = pend_q + CNT_W'(alloc && !alloc_prefilled) - CNT_W'(fill);

        if (pop) begin
            slots_d[head_q].filled = 1'b0;
            head_d = head_q + PTR_ONE;
        end
        if (fill) begin
            slots_d[fill_q].instr  = fill_instr;
            slots_d[fill_q].filled = 1'b1;
            fill_d = fill_q + PTR_ONE;
        end
        // Alloc is applied after pop: on a full queue both may target the same slot.
        if (alloc) begin
            slots_d[tail_q].pc     = alloc_pc;
            slots_d[tail_q].instr  = NOP_INSTR;
            slots_d[tail_q].filled = alloc_prefilled;
`ifdef IFETCH_MISALIGN_CHK_EN
            slots_d[tail_q].misalign = alloc_prefilled;
`endif
            tail_d = tail_q + PTR_ONE;
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_d[i].filled = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slots_q <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            slots_q <= slots_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    assign count     = count_q;
    assign pend      = pend_q;
    assign head_slot = slots_q[head_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC mux, fetch request gating and stale-response flush FSM.
// IFETCH_MISALIGN_CHK_EN adds the if_misalign port and misaligned-PC trapping.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic        if_misalign
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] q_count, q_pend;
    logic [CNT_W-1:0] rsp_adj;
    slot_t            head_slot;
    logic             pop, has_room, fetch_ok, req_fire, fill, alloc;
    logic             pc_misaligned, bad_alloc;

    assign pop      = if_valid && if_ready;
    // A slot freed by decode this cycle can be reused at once, giving 1 instr/cycle at DEPTH=2.
    assign has_room = (q_count < CNT_W'(DEPTH)) || pop;
    assign fetch_ok = !reset && (state_q == FETCH) && has_room && !redirect_valid;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_hold_q, misalign_hold_d;

    assign pc_misaligned = (current_pc[1:0] != 2'b00);
    assign bad_alloc     = fetch_ok && pc_misaligned && !misalign_hold_q;

    always_comb begin
        misalign_hold_d = misalign_hold_q;
        if (redirect_valid) begin
            misalign_hold_d = 1'b0;
        end else if (bad_alloc) begin
            misalign_hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_hold_q <= 1'b0;
        end else begin
            misalign_hold_q <= misalign_hold_d;
        end
    end

    assign if_misalign = if_valid && head_slot.misalign;
`else
    assign pc_misaligned = 1'b0;
    assign bad_alloc     = 1'b0;
`endif

    assign imem_req_valid = fetch_ok && !pc_misaligned;
    assign imem_req_addr  = {current_pc[31:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign alloc          = req_fire || bad_alloc;
    assign fill           = !reset && imem_rsp_valid && (state_q == FETCH) && !redirect_valid;
    assign rsp_adj        = CNT_W'(imem_rsp_valid);

    fetch_slot_queue #(
        .DEPTH(DEPTH)
    ) u_slot_queue (
        .clk             (clk),
        .reset           (reset),
        .flush           (redirect_valid),
        .alloc           (alloc),
        .alloc_pc        (current_pc),
        .alloc_prefilled (bad_alloc),
        .fill            (fill),
        .fill_instr      (imem_rsp_data),
        .pop             (pop),
        .count           (q_count),
        .pend            (q_pend),
        .head_slot       (head_slot)
    );

    assign if_valid = !reset && head_slot.filled && !redirect_valid;
    assign if_pc    = head_slot.pc;
    assign if_instr = head_slot.instr;

    always_comb begin
        if (reset) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (req_fire) begin
            next_pc = current_pc + PC_STEP;
        end else begin
            next_pc = current_pc;
        end
    end

    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            FETCH: begin
                // A response in the redirect cycle is already stale, so it is not counted.
                if (redirect_valid && (q_pend > rsp_adj)) begin
                    state_d    = FLUSH;
                    drop_cnt_d = q_pend - rsp_adj;
                end
            end
            FLUSH: begin
                if (imem_rsp_valid) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                    if (drop_cnt_q == CNT_W'(1)) begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d    = FETCH;
                drop_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC register and fixed-latency memory model.
// Build with IFETCH_MISALIGN_CHK_EN to include the misaligned-PC scenario.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] current_pc = 32'h0;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        if_misalign;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    logic [31:0] mem_addr_q [$];
    int          mem_due_q  [$];

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc     (current_pc),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .if_misalign    (if_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: the PC register loads next_pc, memory accepts/answers with data = addr + 0x1000_0000.
    task automatic tick();
        logic        fire;
        logic        rsp_seen;
        logic [31:0] npc;
        logic [31:0] addr;
        fire     = imem_req_valid && imem_req_ready;
        rsp_seen = imem_rsp_valid;
        npc      = next_pc;
        addr     = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        current_pc = npc;
        if (reset) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (rsp_seen && mem_addr_q.size() != 0) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (fire) begin
                mem_addr_q.push_back(addr);
                mem_due_q.push_back(cyc - 1 + lat);
            end
        end
        if (mem_addr_q.size() != 0 && mem_due_q[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr_q[0] + 32'h1000_0000;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = rdy;
        imem_req_ready = 1'b1;
        tick();
        tick();
        check("rst_req_valid", imem_req_valid, 32'd0);
        check("rst_if_valid", if_valid, 32'd0);
        check("rst_next_pc", next_pc, 32'h0000_0000);
        reset = 1'b0;
        cyc   = 0;
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #1;
    endtask

    task automatic redirect_off();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Streaming, 1-cycle memory, decode always ready.
        lat = 1;
        do_reset(1'b1);
        check("t1_current_pc", current_pc, 32'h0);
        for (int c = 0; c < 6; c++) begin
            check("t1_req_valid", imem_req_valid, 32'd1);
            check("t1_req_addr", imem_req_addr, 32'(c * 4));
            if (c < 2) begin
                check("t1_if_valid_early", if_valid, 32'd0);
            end else begin
                check("t1_if_valid", if_valid, 32'd1);
                check("t1_if_pc", if_pc, 32'(c * 4 - 8));
                check("t1_if_instr", if_instr, 32'h1000_0000 + 32'(c * 4 - 8));
            end
            tick();
        end

        // Decode stalled: two requests then hold at 0x8.
        lat = 1;
        do_reset(1'b0);
        for (int c = 0; c < 2; c++) begin
            check("t2_req_valid", imem_req_valid, 32'd1);
            tick();
        end
        for (int c = 2; c < 5; c++) begin
            check("t2_req_stop", imem_req_valid, 32'd0);
            check("t2_next_pc_hold", next_pc, 32'h8);
            check("t2_if_valid", if_valid, 32'd1);
            check("t2_if_pc", if_pc, 32'h0);
            tick();
        end
        if_ready = 1'b1;
        #1;
        check("t2_resume_valid", imem_req_valid, 32'd1);
        check("t2_resume_addr", imem_req_addr, 32'h8);
        check("t2_resume_next_pc", next_pc, 32'hC);
        tick();
        check("t2_if_pc_next", if_pc, 32'h4);

        // 3-cycle memory, redirect to 0x100 with two requests outstanding.
        lat = 3;
        do_reset(1'b1);
        tick();
        tick();
        check("t3_full_no_req", imem_req_valid, 32'd0);
        redirect_to(32'h100);
        check("t3_next_pc", next_pc, 32'h100);
        check("t3_if_valid_redir", if_valid, 32'd0);
        tick();
        redirect_off();
        for (int c = 3; c < 5; c++) begin
            check("t3_flush_no_req", imem_req_valid, 32'd0);
            check("t3_flush_if_valid", if_valid, 32'd0);
            tick();
        end
        check("t3_new_req_valid", imem_req_valid, 32'd1);
        check("t3_new_req_addr", imem_req_addr, 32'h100);
        for (int c = 5; c < 9; c++) begin
            check("t3_no_stale", if_valid, 32'd0);
            tick();
        end
        check("t3_if_valid", if_valid, 32'd1);
        check("t3_if_pc", if_pc, 32'h100);
        check("t3_if_instr", if_instr, 32'h1000_0100);

        // Redirect in a response cycle, then a second redirect during FLUSH.
        lat = 3;
        do_reset(1'b1);
        tick();
        tick();
        tick();
        redirect_to(32'h200);
        check("t4_next_pc_200", next_pc, 32'h200);
        check("t4_if_valid_redir", if_valid, 32'd0);
        tick();
        redirect_to(32'h300);
        check("t4_flush_no_req", imem_req_valid, 32'd0);
        check("t4_next_pc_300", next_pc, 32'h300);
        tick();
        redirect_off();
        check("t4_req_valid", imem_req_valid, 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h300);
        for (int c = 5; c < 9; c++) begin
            check("t4_no_stale", if_valid, 32'd0);
            tick();
        end
        check("t4_if_valid", if_valid, 32'd1);
        check("t4_if_pc", if_pc, 32'h300);

        // PC wrap at the top of the address space.
        lat = 1;
        do_reset(1'b1);
        redirect_to(32'hFFFF_FFFC);
        check("t5_redir_no_req", imem_req_valid, 32'd0);
        check("t5_next_pc_redir", next_pc, 32'hFFFF_FFFC);
        tick();
        redirect_off();
        check("t5_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        check("t5_next_pc_wrap", next_pc, 32'h0000_0000);
        tick();
        check("t5_req_addr_zero", imem_req_addr, 32'h0000_0000);
        tick();
        check("t5_if_pc_top", if_pc, 32'hFFFF_FFFC);

`ifdef IFETCH_MISALIGN_CHK_EN
        // Misaligned redirect target produces a flagged NOP and no memory request.
        lat = 1;
        do_reset(1'b0);
        redirect_to(32'h102);
        tick();
        redirect_off();
        check("t6_no_req", imem_req_valid, 32'd0);
        check("t6_next_pc_hold", next_pc, 32'h102);
        check("t6_if_valid_early", if_valid, 32'd0);
        tick();
        check("t6_if_valid", if_valid, 32'd1);
        check("t6_if_misalign", if_misalign, 32'd1);
        check("t6_if_instr", if_instr, 32'h0000_0013);
        check("t6_if_pc", if_pc, 32'h102);
        check("t6_no_req_later", imem_req_valid, 32'd0);
        check("t6_next_pc_later", next_pc, 32'h102);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
